// File: rtl/evm_pkg.sv
// Shared types and helpers for the voting-booth ballot controller.
package evm_pkg;

   localparam int unsigned NUM_CAND_DEF = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_CAST,
      ST_HOLD,
      ST_RESULT
   } ballot_state_t;

   function automatic int unsigned popcount(input logic [31:0] v);
      int unsigned n;
      n = 0;
      for (int unsigned i = 0; i < 32; i++) n += 32'(v[i]);
      return n;
   endfunction

endpackage

// File: rtl/button_edge_detect.sv
// Rising-edge detector for candidate buttons; history resets to all-ones so
// buttons already held at reset or arming never register as a press.
module button_edge_detect
   import evm_pkg::*;
#(
   parameter int unsigned NUM_CAND = NUM_CAND_DEF
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NUM_CAND-1:0] button,
   output logic [NUM_CAND-1:0] rise
);

   logic [NUM_CAND-1:0] button_q;

   always_ff @(posedge clock) begin
      if (reset) button_q <= '1;
      else       button_q <= button;
   end

   assign rise = button & ~button_q;

endmodule

// File: rtl/ballot_controller.sv
// Booth ballot sequencer: arms one ballot, emits one one-hot vote pulse, then locks out.
// Optional ARMED abandon timer enabled by defining BALLOT_TIMEOUT_EN.
module ballot_controller
   import evm_pkg::*;
#(
   parameter int unsigned NUM_CAND    = NUM_CAND_DEF,
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned LOCK_CYCLES = 16,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                ballot_issue,
   input  logic                mode,
   input  logic [NUM_CAND-1:0] button,
   output logic [NUM_CAND-1:0] vote_pulse,
   output logic                log_mode,
   output logic                ballot_ready,
   output logic                busy,
   output logic [CNT_W-1:0]    total_votes,
   output logic                timeout_flag
);

   localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);

   ballot_state_t       state;
   logic [NUM_CAND-1:0] rise;
   logic [LOCK_W-1:0]   lock_cnt;
   logic                valid_press;
   logic                timeout_hit;

   button_edge_detect #(.NUM_CAND(NUM_CAND)) u_edge (
      .clock  (clock),
      .reset  (reset),
      .button (button),
      .rise   (rise)
   );

   // Simultaneous multi-button edges are ambiguous and therefore discarded.
   assign valid_press = (popcount(32'(rise)) == 1);

`ifdef BALLOT_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] tmo_cnt;

   assign timeout_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clock) begin
      if (reset || state != ST_ARMED || mode || valid_press || timeout_hit)
         tmo_cnt <= '0;
      else
         tmo_cnt <= tmo_cnt + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset)
         timeout_flag <= 1'b0;
      else if (state == ST_ARMED && !mode && !valid_press && timeout_hit)
         timeout_flag <= 1'b1;
   end
`else
   assign timeout_hit  = 1'b0;
   // Constant 0 for any legal TIMEOUT_CYC; no timer exists in this build.
   assign timeout_flag = (TIMEOUT_CYC == 0);
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= ST_IDLE;
         vote_pulse   <= '0;
         log_mode     <= 1'b1;
         ballot_ready <= 1'b0;
         busy         <= 1'b0;
         total_votes  <= '0;
         lock_cnt     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (mode) begin
                  state <= ST_RESULT;
               end else if (ballot_issue) begin
                  state        <= ST_ARMED;
                  ballot_ready <= 1'b1;
                  log_mode     <= 1'b0;
               end
            end
            ST_ARMED: begin
               if (mode) begin
                  state        <= ST_RESULT;
                  ballot_ready <= 1'b0;
                  log_mode     <= 1'b1;
               end else if (valid_press) begin
                  state        <= ST_CAST;
                  vote_pulse   <= rise;
                  ballot_ready <= 1'b0;
                  busy         <= 1'b1;
                  if (total_votes != '1) total_votes <= total_votes + 1'b1;
               end else if (timeout_hit) begin
                  state        <= ST_IDLE;
                  ballot_ready <= 1'b0;
                  log_mode     <= 1'b1;
               end
            end
            ST_CAST: begin
               state      <= ST_HOLD;
               vote_pulse <= '0;
               log_mode   <= 1'b1;
               lock_cnt   <= LOCK_W'(LOCK_CYCLES);
            end
            ST_HOLD: begin
               if (lock_cnt != '0) begin
                  lock_cnt <= lock_cnt - 1'b1;
               end else if (button == '0) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            ST_RESULT: begin
               if (!mode) state <= ST_IDLE;
            end
            default: begin
               state        <= ST_IDLE;
               vote_pulse   <= '0;
               log_mode     <= 1'b1;
               ballot_ready <= 1'b0;
               busy         <= 1'b0;
            end
         endcase
      end
   end

endmodule
